// File: rtl/iobus16_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iobus16_ctrl_pkg
// Brief   : Shared types and constants for the 16-bit tristate bus sequencer.
//           Related build macro: IOBUS16_CTRL_RR_EN (see iobus16_arb).
// Revision: 1.0 - initial release
// ============================================================================
package iobus16_ctrl_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DRIVE = 3'd1,
    ST_WR_HOLD  = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_CAP   = 3'd4,
    ST_TURN     = 3'd5
  } iobus_state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  // Largest of three timing parameters; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iobus16_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : iobus16_ctrl_if
// Brief   : Requester, external strobe and IOBUF-bank signals of the
//           16-bit bus sequencer. slave = sequencer view, master = the
//           requesters plus the pin-side model.
// Revision: 1.0 - initial release
// ============================================================================
interface iobus16_ctrl_if #(
  parameter int ADDR_W = 18
);
  import iobus16_ctrl_pkg::*;

  // requester side
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [BUS_W-1:0]  wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [BUS_W-1:0]  rd_data;
  logic              rd_valid;
  logic              busy;
  // external bus / IOBUF side
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_cs_n;
  logic              bus_we_n;
  logic              bus_oe_n;
  logic [BUS_W-1:0]  io_o;
  logic              io_t;
  logic [BUS_W-1:0]  io_i;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, io_i,
    output wr_ack, rd_ack, rd_data, rd_valid, busy,
           bus_addr, bus_cs_n, bus_we_n, bus_oe_n, io_o, io_t
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, io_i,
    input  wr_ack, rd_ack, rd_data, rd_valid, busy,
           bus_addr, bus_cs_n, bus_we_n, bus_oe_n, io_o, io_t
  );

endinterface
`default_nettype wire

// File: rtl/iobus16_arb.sv
`default_nettype none
// ============================================================================
// Module  : iobus16_arb
// Brief   : Two-way write/read arbiter.
//           IOBUS16_CTRL_RR_EN defined  : round-robin when both request.
//           IOBUS16_CTRL_RR_EN undefined: fixed priority, read wins.
// Revision: 1.0 - initial release
// ============================================================================
module iobus16_arb
  import iobus16_ctrl_pkg::*;
(
  input  logic   req_wr_i,
  input  logic   req_rd_i,
  input  grant_t last_grant_i,
  output grant_t grant_o
);

`ifdef IOBUS16_CTRL_RR_EN
  // Contention goes to the side that lost last time; a lone request always wins.
  always_comb begin
    grant_o = GRANT_WR;
    if (req_wr_i && req_rd_i) begin
      grant_o = (last_grant_i == GRANT_WR) ? GRANT_RD : GRANT_WR;
    end else if (req_rd_i) begin
      grant_o = GRANT_RD;
    end
  end
`else
  // History is irrelevant with fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Read has priority; with nothing pending the value is ignored by the caller.
  always_comb begin
    grant_o = GRANT_WR;
    if (req_rd_i) begin
      grant_o = GRANT_RD;
    end else if (req_wr_i) begin
      grant_o = GRANT_WR;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/iobus16_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : iobus16_ctrl
// Brief   : Sequencer for a 16-bit half-duplex tristate bus driven through a
//           bank of IOBUF primitives. Arbitrates one writer and one reader,
//           generates cs/we/oe timing and enforces a bus turnaround after
//           every read. Arbitration mode selected by IOBUS16_CTRL_RR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module iobus16_ctrl
  import iobus16_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WR_CYCLES   = 2,
  parameter int RD_LATENCY  = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  iobus16_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(max3(WR_CYCLES, RD_LATENCY, TURN_CYCLES) + 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  iobus_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  grant_t            last_grant_q, last_grant_d;
  grant_t            grant;

  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [BUS_W-1:0]  io_o_q, io_o_d;
  logic [BUS_W-1:0]  rd_data_q, rd_data_d;
  logic              cs_n_q, cs_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              io_t_q, io_t_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;

  iobus16_arb u_arb (
    .req_wr_i     (bus.wr_req),
    .req_rd_i     (bus.rd_req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Next-state logic; every state that waits reloads the counter on entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.wr_req || bus.rd_req) begin
          last_grant_d = grant;
          if (grant == GRANT_RD) begin
            state_d = ST_RD_WAIT;
            cnt_d   = RD_LOAD;
          end else begin
            state_d = ST_WR_DRIVE;
            cnt_d   = WR_LOAD;
          end
        end
      end
      ST_WR_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_CAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RD_CAP: begin
        state_d = ST_TURN;
        cnt_d   = TURN_LOAD;
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values decoded from the upcoming state so every pin is a flop.
  // io_t can only be low in write states and oe_n only in read states, and
  // IDLE always separates TURN from the next write, so the FPGA never
  // drives while the device may still be driving.
  always_comb begin
    bus_addr_d = bus_addr_q;
    io_o_d     = io_o_q;
    rd_data_d  = rd_data_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    if (state_q == ST_IDLE && state_d == ST_WR_DRIVE) begin
      wr_ack_d   = 1'b1;
      bus_addr_d = bus.wr_addr;
      io_o_d     = bus.wr_data;
    end
    if (state_q == ST_IDLE && state_d == ST_RD_WAIT) begin
      rd_ack_d   = 1'b1;
      bus_addr_d = bus.rd_addr;
    end
    if (state_q == ST_RD_CAP) begin
      rd_data_d  = bus.io_i;
      rd_valid_d = 1'b1;
    end
    cs_n_d = !(state_d inside {ST_WR_DRIVE, ST_WR_HOLD, ST_RD_WAIT, ST_RD_CAP});
    we_n_d = (state_d != ST_WR_DRIVE);
    oe_n_d = !(state_d inside {ST_RD_WAIT, ST_RD_CAP});
    io_t_d = !(state_d inside {ST_WR_DRIVE, ST_WR_HOLD});
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_WR;
      bus_addr_q   <= '0;
      io_o_q       <= '0;
      rd_data_q    <= '0;
      cs_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      io_t_q       <= 1'b1;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      bus_addr_q   <= bus_addr_d;
      io_o_q       <= io_o_d;
      rd_data_q    <= rd_data_d;
      cs_n_q       <= cs_n_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      io_t_q       <= io_t_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.bus_addr = bus_addr_q;
  assign bus.io_o     = io_o_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.bus_cs_n = cs_n_q;
  assign bus.bus_we_n = we_n_q;
  assign bus.bus_oe_n = oe_n_q;
  assign bus.io_t     = io_t_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_iobus16_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_iobus16_ctrl
// Brief   : Directed and random self-checking bench for iobus16_ctrl.
//           Arbitration expectations follow IOBUS16_CTRL_RR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iobus16_ctrl;

  localparam int ADDR_W      = 18;
  localparam int WR_CYCLES   = 2;
  localparam int RD_LATENCY  = 2;
  localparam int TURN_CYCLES = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] dev_val = 16'h0000;
  int          total = 0;
  int          bad   = 0;

  iobus16_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

  // External device: drives the pins only while output-enabled.
  assign bif.io_i = (bif.bus_oe_n == 1'b0) ? dev_val : 16'h0000;

  iobus16_ctrl #(
    .ADDR_W      (ADDR_W),
    .WR_CYCLES   (WR_CYCLES),
    .RD_LATENCY  (RD_LATENCY),
    .TURN_CYCLES (TURN_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for an ack; n = negedges waited.
  task automatic wait_ack(input bit is_rd, input int limit, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      if (is_rd ? bif.rd_ack : bif.wr_ack) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bif.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bif.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout: busy=%b want 0", name, bif.busy);
    end
  endtask

  task automatic test_reset();
    bif.wr_req = 1'b0; bif.rd_req = 1'b0;
    bif.wr_addr = '0; bif.rd_addr = '0; bif.wr_data = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bif.io_t, bif.bus_cs_n, bif.bus_we_n, bif.bus_oe_n,
         bif.wr_ack, bif.rd_ack, bif.rd_valid, bif.busy} !== 8'b1111_0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 11110000",
               {bif.io_t, bif.bus_cs_n, bif.bus_we_n, bif.bus_oe_n,
                bif.wr_ack, bif.rd_ack, bif.rd_valid, bif.busy});
    end
    total++;
    if (bif.io_o !== 16'h0 || bif.bus_addr !== 18'h0 || bif.rd_data !== 16'h0) begin
      bad++;
      $display("FAIL reset_data: io_o=%h addr=%h rd_data=%h want 0/0/0",
               bif.io_o, bif.bus_addr, bif.rd_data);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit ok; int n;
    bif.wr_addr = 18'h00010; bif.wr_data = 16'h0123; bif.wr_req = 1'b1;
    wait_ack(1'b0, 10, ok, n);
    bif.wr_req = 1'b0;
    total++;
    if (!ok || n != 1) begin
      bad++;
      $display("FAIL wr_ack_latency: ok=%0d cycles=%0d want 1/1", ok, n);
    end
    // first WR_DRIVE cycle
    total++;
    if ({bif.bus_we_n, bif.io_t, bif.bus_cs_n, bif.bus_oe_n, bif.busy} !== 5'b00011) begin
      bad++;
      $display("FAIL wr_drive1: got %b want 00011",
               {bif.bus_we_n, bif.io_t, bif.bus_cs_n, bif.bus_oe_n, bif.busy});
    end
    total++;
    if (bif.io_o !== 16'h0123 || bif.bus_addr !== 18'h00010) begin
      bad++;
      $display("FAIL wr_bus_data: io_o=%h addr=%h want 0123/00010", bif.io_o, bif.bus_addr);
    end
    @(negedge clk);  // second WR_DRIVE cycle, ack already gone
    total++;
    if ({bif.wr_ack, bif.bus_we_n, bif.io_t} !== 3'b000) begin
      bad++;
      $display("FAIL wr_drive2: got %b want 000", {bif.wr_ack, bif.bus_we_n, bif.io_t});
    end
    @(negedge clk);  // WR_HOLD
    total++;
    if ({bif.bus_we_n, bif.io_t, bif.bus_cs_n} !== 3'b100 || bif.io_o !== 16'h0123) begin
      bad++;
      $display("FAIL wr_hold: we_n/io_t/cs_n=%b io_o=%h want 100/0123",
               {bif.bus_we_n, bif.io_t, bif.bus_cs_n}, bif.io_o);
    end
    @(negedge clk);  // back in IDLE
    total++;
    if ({bif.io_t, bif.bus_cs_n, bif.bus_we_n, bif.busy} !== 4'b1110) begin
      bad++;
      $display("FAIL wr_release: got %b want 1110",
               {bif.io_t, bif.bus_cs_n, bif.bus_we_n, bif.busy});
    end
  endtask

  task automatic test_read();
    bit ok; int n;
    dev_val = 16'hBEEF;
    bif.rd_addr = 18'h00020; bif.rd_req = 1'b1;
    wait_ack(1'b1, 10, ok, n);
    bif.rd_req = 1'b0;
    total++;
    if (!ok || n != 1) begin
      bad++;
      $display("FAIL rd_ack_latency: ok=%0d cycles=%0d want 1/1", ok, n);
    end
    total++;
    if ({bif.bus_oe_n, bif.bus_cs_n, bif.io_t, bif.bus_we_n} !== 4'b0011 ||
        bif.bus_addr !== 18'h00020) begin
      bad++;
      $display("FAIL rd_strobes: oe/cs/t/we=%b addr=%h want 0011/00020",
               {bif.bus_oe_n, bif.bus_cs_n, bif.io_t, bif.bus_we_n}, bif.bus_addr);
    end
    @(negedge clk); @(negedge clk);  // RD_WAIT, RD_CAP
    total++;
    if (bif.bus_oe_n !== 1'b0 || bif.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_cap: oe_n=%b rd_valid=%b want 0/0", bif.bus_oe_n, bif.rd_valid);
    end
    @(negedge clk);  // TURN: valid pulse, strobes released
    total++;
    if ({bif.rd_valid, bif.bus_oe_n, bif.bus_cs_n, bif.io_t, bif.busy} !== 5'b11111 ||
        bif.rd_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL rd_valid: v/oe/cs/t/busy=%b data=%h want 11111/beef",
               {bif.rd_valid, bif.bus_oe_n, bif.bus_cs_n, bif.io_t, bif.busy}, bif.rd_data);
    end
    @(negedge clk);  // IDLE: data held
    total++;
    if ({bif.rd_valid, bif.busy} !== 2'b00 || bif.rd_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL rd_hold: v/busy=%b data=%h want 00/beef",
               {bif.rd_valid, bif.busy}, bif.rd_data);
    end
  endtask

  task automatic test_read_then_write();
    bit ok; int n;
    logic [2:0] exp_seq [1:5];  // {bus_oe_n, io_t, wr_ack}
    exp_seq[1] = 3'b010;  // RD_WAIT
    exp_seq[2] = 3'b010;  // RD_CAP
    exp_seq[3] = 3'b110;  // TURN
    exp_seq[4] = 3'b110;  // IDLE
    exp_seq[5] = 3'b101;  // WR_DRIVE
    dev_val = 16'h1357;
    bif.rd_addr = 18'h30004; bif.rd_req = 1'b1;
    wait_ack(1'b1, 10, ok, n);
    bif.rd_req = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rtw_rd_ack: got timeout want ack");
    end
    bif.wr_addr = 18'h2ABCD; bif.wr_data = 16'hC0DE; bif.wr_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 5) bif.wr_req = 1'b0;
      total++;
      if ({bif.bus_oe_n, bif.io_t, bif.wr_ack} !== exp_seq[i]) begin
        bad++;
        $display("FAIL rtw_step%0d: oe_n/io_t/wr_ack=%b want %b",
                 i, {bif.bus_oe_n, bif.io_t, bif.wr_ack}, exp_seq[i]);
      end
      if (i == 3) begin
        total++;
        if (bif.rd_valid !== 1'b1 || bif.rd_data !== 16'h1357) begin
          bad++;
          $display("FAIL rtw_rd_data: v=%b data=%h want 1/1357", bif.rd_valid, bif.rd_data);
        end
      end
    end
    wait_idle("rtw");
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_rd;  // bit r set = read expected in round r
    logic [2:0] got;
    int n;
`ifdef IOBUS16_CTRL_RR_EN
    exp_rd = 3'b101;  // R, W, R
`else
    exp_rd = 3'b111;  // R, R, R
`endif
    got = 3'b000;
    // fresh reset so the arbitration history starts at WRITE
    bif.wr_req = 1'b0; bif.rd_req = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bif.wr_addr = 18'h00111; bif.wr_data = 16'hAAAA; bif.rd_addr = 18'h00222;
    bif.wr_req = 1'b1; bif.rd_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (bif.wr_ack !== 1'b1 && bif.rd_ack !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (bif.rd_ack === 1'b1) begin
        got[r] = 1'b1;
        bif.rd_req = 1'b0;
      end else if (bif.wr_ack === 1'b1) begin
        got[r] = 1'b0;
        bif.wr_req = 1'b0;
      end else begin
        bad++;
        $display("FAIL arb_round%0d: got no ack want ack", r);
      end
      if (got[r] !== exp_rd[r]) begin
        bad++;
        $display("FAIL arb_round%0d: read_granted=%b want %b", r, got[r], exp_rd[r]);
      end
      @(negedge clk);
      if (r < 2) begin
        bif.wr_req = 1'b1; bif.rd_req = 1'b1;
      end else begin
        bif.wr_req = 1'b0; bif.rd_req = 1'b0;
      end
    end
    wait_idle("arb");
  endtask

  task automatic test_reset_mid_op();
    bit ok; int n;
    bif.wr_addr = 18'h00033; bif.wr_data = 16'h5555; bif.wr_req = 1'b1;
    wait_ack(1'b0, 10, ok, n);
    bif.wr_req = 1'b0;
    total++;
    if (!ok || {bif.bus_we_n, bif.io_t} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_pre: ok=%0d we_n/io_t=%b want 1/00", ok, {bif.bus_we_n, bif.io_t});
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bif.io_t, bif.bus_we_n, bif.bus_cs_n, bif.bus_oe_n, bif.busy, bif.wr_ack} !== 6'b111100) begin
      bad++;
      $display("FAIL rstmid_release: got %b want 111100",
               {bif.io_t, bif.bus_we_n, bif.bus_cs_n, bif.bus_oe_n, bif.busy, bif.wr_ack});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({bif.wr_ack, bif.rd_ack, bif.rd_valid, bif.busy} !== 4'b0000) begin
        bad++;
        $display("FAIL rstmid_quiet%0d: ack/ack/valid/busy=%b want 0000",
                 i, {bif.wr_ack, bif.rd_ack, bif.rd_valid, bif.busy});
      end
    end
  endtask

  task automatic test_random();
    int          since_oe;
    int          reads;
    logic [15:0] exp_rd;
    since_oe = 1000;
    reads    = 0;
    exp_rd   = 16'h0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (bif.bus_oe_n === 1'b0) since_oe = 0;
      else if (since_oe < 1000) since_oe++;
      total++;
      if (bif.io_t === 1'b0 && bif.bus_oe_n === 1'b0) begin
        bad++;
        $display("FAIL rand_overlap@%0d: io_t=0 with oe_n=0", c);
      end
      // after oe_n rises: TURN_CYCLES of TURN plus one IDLE before io_t may fall
      if (bif.io_t === 1'b0) begin
        total++;
        if (since_oe < TURN_CYCLES + 2) begin
          bad++;
          $display("FAIL rand_turn@%0d: io_t=0 %0d cycles after oe_n low want >=%0d",
                   c, since_oe, TURN_CYCLES + 2);
        end
      end
      if (bif.rd_valid === 1'b1) begin
        reads++;
        total++;
        if (bif.rd_data !== exp_rd) begin
          bad++;
          $display("FAIL rand_rd_data@%0d: got %h want %h", c, bif.rd_data, exp_rd);
        end
      end
      dev_val      = 16'($urandom);
      bif.wr_req   = ($urandom_range(0, 3) != 0);
      bif.rd_req   = ($urandom_range(0, 1) != 0);
      bif.wr_addr  = 18'($urandom);
      bif.rd_addr  = 18'($urandom);
      bif.wr_data  = 16'($urandom);
      if (bif.bus_oe_n === 1'b0) exp_rd = dev_val;
    end
    bif.wr_req = 1'b0; bif.rd_req = 1'b0;
    total++;
    if (reads == 0) begin
      bad++;
      $display("FAIL rand_reads: got 0 completed reads want >0");
    end
    wait_idle("rand");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_then_write();
    test_arbitration();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
